// File: rtl/serial_adder_host.sv
// -----------------------------------------------------------------------------
// serial_adder_host
//
// Host-side partner of a bit-serial 4-bit adder. Operand pairs arrive over a
// valid/ready handshake. They are shifted out LSB-first on line1/line2 in
// continuous 4-cycle frames that are phase-locked to the adder. The serial sum
// bits and the late overflow flag are gathered back into a parallel result
// register.
//
// The host owns the adder's reset, so both ends leave reset at frame phase 0.
//
// Optional build macro:
//   SERIAL_ADDER_HOST_CHECK_EN - builds a local A+B reference. The reference
//   is compared with every result as it is written, and chk_err is set
//   (sticky) on any mismatch. When the macro is undefined, chk_err is tied
//   to 0.
//
// Parameters:
//   FRAME_BITS  bits per frame; fixed by the adder, only 4 is legal
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   adder_rst  out  synchronous active-high reset to the adder
//   op_valid   in   operand pair offered
//   op_ready   out  operand holding register empty
//   op_a       in   operand A (serialised on line1)
//   op_b       in   operand B (serialised on line2)
//   line1      out  serial A bit, registered
//   line2      out  serial B bit, registered
//   outp       in   serial sum bit from the adder
//   overflw    in   adder overflow flag for the previous frame
//   res_valid  out  result register full
//   res_ready  in   result consumed when res_valid && res_ready
//   res_sum    out  (A+B) mod 16
//   res_ovf    out  carry out of bit 3
//   res_lost   out  sticky: an unconsumed result was overwritten
//   chk_err    out  sticky self-check mismatch
// -----------------------------------------------------------------------------
module serial_adder_host #(
  parameter int FRAME_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  adder_rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [FRAME_BITS-1:0] op_a,
  input  logic [FRAME_BITS-1:0] op_b,
  output logic                  line1,
  output logic                  line2,
  input  logic                  outp,
  input  logic                  overflw,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [FRAME_BITS-1:0] res_sum,
  output logic                  res_ovf,
  output logic                  res_lost,
  output logic                  chk_err
);

  // Startup sequencing: hold the adder in reset for exactly one edge after
  // reset_n releases. Frames then run forever.
  typedef enum logic {
    ST_ADDER_RST,
    ST_RUN
  } ctrl_state_t;

  ctrl_state_t state_q, state_d;

  logic [1:0]            phase;
  logic                  running;
  logic                  frame_end;
  logic                  new_result;

  logic                  hold_full;
  logic [FRAME_BITS-1:0] hold_a;
  logic [FRAME_BITS-1:0] hold_b;

  logic [FRAME_BITS-2:0] a_sr;
  logic [FRAME_BITS-2:0] b_sr;
  logic                  cur_real;
  logic                  cap_real;
  logic [FRAME_BITS-1:0] sum_sr;
  logic [1:0]            cap_idx;

  logic                  op_hs;
  logic                  res_hs;

  assign op_hs  = op_valid && op_ready;
  assign res_hs = res_valid && res_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ADDER_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // frame_end marks the edge that closes phase 3. new_result marks the edge
  // that closes phase 1. By then the previous frame's four sum bits and its
  // overflow flag have all arrived.
  always_comb begin
    state_d    = state_q;
    adder_rst  = 1'b0;
    running    = 1'b0;
    frame_end  = 1'b0;
    new_result = 1'b0;
    case (state_q)
      ST_ADDER_RST: begin
        adder_rst = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        running    = 1'b1;
        frame_end  = (phase == 2'd3);
        new_result = (phase == 2'd1) && cap_real;
      end
      default: begin
        state_d = ST_ADDER_RST;
      end
    endcase
  end

  // The phase counter stays at 0 through the adder-reset edge. After that it
  // free-runs and never stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= 2'd0;
    end else if (running) begin
      phase <= phase + 2'd1;
    end
  end

  // Operand holding register. It drains only at a frame boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_ready  <= 1'b0;
      hold_full <= 1'b0;
      hold_a    <= '0;
      hold_b    <= '0;
    end else begin
      if (state_q == ST_ADDER_RST) begin
        op_ready <= 1'b1;
      end else if (op_hs) begin
        op_ready  <= 1'b0;
        hold_full <= 1'b1;
        hold_a    <= op_a;
        hold_b    <= op_b;
      end else if (frame_end && hold_full) begin
        op_ready  <= 1'b1;
        hold_full <= 1'b0;
      end
    end
  end

  // Bit 0 goes straight onto the lines at the frame boundary. The upper bits
  // wait in the shift registers. An empty holding register produces an idle
  // frame of zeros.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line1    <= 1'b0;
      line2    <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      cur_real <= 1'b0;
      cap_real <= 1'b0;
    end else if (frame_end) begin
      line1    <= hold_full & hold_a[0];
      line2    <= hold_full & hold_b[0];
      a_sr     <= hold_full ? hold_a[FRAME_BITS-1:1] : '0;
      b_sr     <= hold_full ? hold_b[FRAME_BITS-1:1] : '0;
      cur_real <= hold_full;
      cap_real <= cur_real;
    end else if (running) begin
      line1 <= a_sr[0];
      line2 <= b_sr[0];
      a_sr  <= {1'b0, a_sr[FRAME_BITS-2:1]};
      b_sr  <= {1'b0, b_sr[FRAME_BITS-2:1]};
    end
  end

  // The adder registers each sum bit one edge after sampling. The bit that
  // arrives at the edge closing phase p is therefore bit p-1 (mod 4). The
  // next frame's bit 0 replaces sum_sr[0] on the same edge that reads out
  // the full previous sum.
  assign cap_idx = phase - 2'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_sr <= '0;
    end else if (running) begin
      sum_sr[cap_idx] <= outp;
    end
  end

  // When a new result coincides with a handshake, the new result wins and
  // nothing is counted as lost.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_ovf   <= 1'b0;
      res_lost  <= 1'b0;
    end else if (new_result) begin
      res_valid <= 1'b1;
      res_sum   <= sum_sr;
      res_ovf   <= overflw;
      if (res_valid && !res_ready) begin
        res_lost <= 1'b1;
      end
    end else if (res_hs) begin
      res_valid <= 1'b0;
    end
  end

`ifdef SERIAL_ADDER_HOST_CHECK_EN
  // Two reference entries travel alongside the real/idle tags: one for the
  // frame on the lines and one for the frame being collected.
  logic [FRAME_BITS:0] cur_exp;
  logic [FRAME_BITS:0] cap_exp;
  logic                chk_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_exp   <= '0;
      cap_exp   <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (frame_end) begin
        cur_exp <= hold_full ? ({1'b0, hold_a} + {1'b0, hold_b}) : '0;
        cap_exp <= cur_exp;
      end
      if (new_result && ({overflw, sum_sr} != cap_exp)) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
